// File: rtl/spike_in_arb_pkg.sv
// Shared types, default sizing and helpers for the spike-input round-robin arbiter.
package spike_in_arb_pkg;

  // Arbiter FSM: IDLE arbitrates, OWN streams one frame from the owner.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  localparam int IO_WIDTH_DEF        = 8;
  localparam int NUM_SRC_DEF         = 2;
  localparam int WORDS_PER_FRAME_DEF = 4;
  localparam int BEATS_PER_WORD      = 16 / IO_WIDTH_DEF;
  localparam int FRAME_BEATS         = WORDS_PER_FRAME_DEF * BEATS_PER_WORD;

  // Ceiling log2 with a floor of one bit, so a 1-entry range still gets a register.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Beats in one granted frame for a given beat width and word count.
  function automatic int calc_frame_beats(input int io_w, input int words);
    return words * (16 / io_w);
  endfunction

endpackage

// File: rtl/spike_in_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after last_owner+1.
module rr_pick
  import spike_in_arb_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int IDX_W   = clog2_min1(NUM_SRC_DEF)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   last_owner_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic found_s;
  logic hit_s;
  int   cand_s;

  // Walk the sources in rotated priority order; the first hit wins.
  always_comb begin
    gnt_o   = {NUM_SRC{1'b0}};
    idx_o   = {IDX_W{1'b0}};
    found_s = 1'b0;
    hit_s   = 1'b0;
    cand_s  = 0;
    for (int off = 1; off <= NUM_SRC; off++) begin
      cand_s        = (int'(last_owner_i) + off) % NUM_SRC;
      hit_s         = req_i[cand_s] & ~found_s;
      gnt_o[cand_s] = gnt_o[cand_s] | hit_s;
      idx_o         = hit_s ? IDX_W'(cand_s) : idx_o;
      found_s       = found_s | hit_s;
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/spike_in_arb.sv
// Frame-granular round-robin arbiter in front of the spike-input deserializer.
// A grant is held for FRAME_BEATS transfers so words never mix sources.
module spike_in_arb
  import spike_in_arb_pkg::*;
#(
  parameter int IO_WIDTH        = IO_WIDTH_DEF,
  parameter int NUM_SRC         = NUM_SRC_DEF,
  parameter int WORDS_PER_FRAME = WORDS_PER_FRAME_DEF
) (
  input  logic                         CLK,
  input  logic                         RSTB,
  input  logic [NUM_SRC-1:0]           REQ_VALID,
  input  logic [NUM_SRC*IO_WIDTH-1:0]  REQ_SPIKE,
  output logic [NUM_SRC-1:0]           REQ_READY,
  output logic                         OUT_VALID,
  output logic [IO_WIDTH-1:0]          OUT_SPIKE,
  input  logic                         BP,
  output logic [NUM_SRC-1:0]           GRANT,
  output logic                         FRAME_DONE
);

  localparam int FB    = calc_frame_beats(IO_WIDTH, WORDS_PER_FRAME);
  localparam int CNT_W = clog2_min1(FB);
  localparam int IDX_W = clog2_min1(NUM_SRC);

  arb_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_owner_q, last_owner_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               frame_done_q, frame_done_d;

  logic [NUM_SRC-1:0] pick_gnt_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               pick_any_s;
  logic               xfer_s;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i        (REQ_VALID),
    .last_owner_i (last_owner_q),
    .gnt_o        (pick_gnt_s),
    .idx_o        (pick_idx_s),
    .any_o        (pick_any_s)
  );

  // Next-state, counter and zero-latency data mux for the owning source.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    frame_done_d = 1'b0;
    REQ_READY    = {NUM_SRC{1'b0}};
    OUT_VALID    = 1'b0;
    OUT_SPIKE    = {IO_WIDTH{1'b0}};
    xfer_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any_s) begin
          grant_d = pick_gnt_s;
          owner_d = pick_idx_s;
          state_d = ST_OWN;
        end else begin
          grant_d = {NUM_SRC{1'b0}};
        end
      end
      ST_OWN: begin
        OUT_VALID          = REQ_VALID[owner_q];
        OUT_SPIKE          = REQ_SPIKE[int'(owner_q)*IO_WIDTH +: IO_WIDTH];
        REQ_READY[owner_q] = ~BP;
        xfer_s             = REQ_VALID[owner_q] & ~BP;
        if (xfer_s) begin
          if (beat_cnt_q == CNT_W'(FB - 1)) begin
            beat_cnt_d   = {CNT_W{1'b0}};
            last_owner_d = owner_q;
            frame_done_d = 1'b1;
            grant_d      = {NUM_SRC{1'b0}};
            state_d      = ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = {NUM_SRC{1'b0}};
      end
    endcase
  end

  // State, grant, counter and frame-done registers; last owner resets so source 0 wins first.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q      <= ST_IDLE;
      grant_q      <= {NUM_SRC{1'b0}};
      owner_q      <= {IDX_W{1'b0}};
      last_owner_q <= IDX_W'(NUM_SRC - 1);
      beat_cnt_q   <= {CNT_W{1'b0}};
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign GRANT      = grant_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: doc/spike_in_arb.md
# spike_in_arb

Round-robin arbiter that shares the chip's single narrow spike-input port between several spike sources, e.g. the host pad interface and an on-chip pattern generator. It sits directly upstream of the input deserializer that packs IO_WIDTH-bit beats into 16-bit spike vectors. Grant is held for a whole frame of beats, so chunks from different sources never interleave and the deserializer's beat counter stays word-aligned. Backpressure (BP) from the deserializer is honoured per beat.

## Interface
- IO_WIDTH, 8: beat width; must divide 16.
- NUM_SRC, 2: number of requesters, 2..4.
- WORDS_PER_FRAME, 4: 16-bit words per granted frame; frame length FRAME_BEATS = WORDS_PER_FRAME*16/IO_WIDTH.

- CLK  in  1  single clock, rising edge.
- RSTB  in  1  asynchronous, active-low reset.
- REQ_VALID  in  NUM_SRC  per-source beat valid.
- REQ_SPIKE  in  NUM_SRC*IO_WIDTH  per-source beat; source i occupies bits [i*IO_WIDTH +: IO_WIDTH].
- REQ_READY  out  NUM_SRC  per-source beat accepted this cycle when high together with REQ_VALID.
- OUT_VALID  out  1  to deserializer IN_VALID.
- OUT_SPIKE  out  IO_WIDTH  to deserializer IN_SPIKE.
- BP  in  1  downstream backpressure; no beat is consumed while high.
- GRANT  out  NUM_SRC  one-hot owner, all-zero when idle.
- FRAME_DONE  out  1  one-cycle pulse after a frame's last beat.

## Operation
- FSM states IDLE and OWN; reset state IDLE.
- IDLE: if any REQ_VALID is high, pick the first requester at or after index (last_owner+1) mod NUM_SRC. Register GRANT to that index and go to OWN. With no requests, stay in IDLE and hold GRANT at 0.
- OWN, with owner g:
  - OUT_VALID = REQ_VALID[g]; OUT_SPIKE = REQ_SPIKE[g] (combinational mux).
  - REQ_READY[g] = ~BP. All other REQ_READY bits are 0.
  - Transfer = REQ_VALID[g] & ~BP. On each transfer, beat_cnt increments.
  - On the transfer where beat_cnt == FRAME_BEATS-1: clear beat_cnt, set last_owner = g, register FRAME_DONE=1, clear GRANT, go to IDLE.
- No preemption. If the owner drops REQ_VALID mid-frame, grant stays with it, OUT_VALID is 0 and beat_cnt holds.
- BP high: beat_cnt and all state hold, and OUT_VALID still reflects the owner's valid. The deserializer gates on BP itself.
- In IDLE, OUT_VALID=0, OUT_SPIKE=0 and REQ_READY=0.
- beat_cnt width is clog2(FRAME_BEATS), minimum 1. It never wraps past FRAME_BEATS-1.
- last_owner resets to NUM_SRC-1, so source 0 wins the first arbitration.

## Timing
- Reset values: GRANT=0, FRAME_DONE=0, OUT_VALID=0, OUT_SPIKE=0, REQ_READY=0, beat_cnt=0, state IDLE.
- Arbitration costs one bubble: a request seen in IDLE at edge k gives GRANT at k+1, and the first beat can transfer in cycle k+1.
- Data path has zero latency: OUT_* and REQ_READY are combinational from REQ_* and BP in OWN.
- FRAME_DONE is high for exactly the cycle after the last transfer. In that cycle state is IDLE, so the next grant appears one cycle later. Minimum gap between frames is 1 idle cycle.
- A requester raising valid in the same cycle FRAME_DONE pulses is eligible in that IDLE cycle.
- An RSTB assertion mid-frame returns all state to reset values immediately. The deserializer shares RSTB, so no partial word survives.

## Structure
- Shared package holds:
  - the state enum (IDLE, OWN);
  - localparams BEATS_PER_WORD = 16/IO_WIDTH and FRAME_BEATS;
  - a clog2 helper for the beat_cnt width.
- One sub-module, rr_pick: a combinational round-robin picker taking a request vector and last_owner and returning a one-hot grant plus index. The FSM, counter and mux stay in spike_in_arb.

## Test plan
All scenarios use IO_WIDTH=8, NUM_SRC=2 and WORDS_PER_FRAME=4, giving FRAME_BEATS=8.

1. Single source: after reset, src0 streams beats 0x01..0x08 with BP=0.
   -> GRANT=01 from cycle 1; eight OUT_VALID beats 0x01..0x08; FRAME_DONE in cycle 9; deserializer emits words 0x0201, 0x0403, 0x0605, 0x0807.
2. Contention: both sources valid continuously.
   -> grants alternate 01, 10, 01. Each grant gets exactly 8 transfers and 1 idle cycle between frames. No src1 beat appears inside a src0 frame.
3. Backpressure: BP high for 3 cycles after beat 3 of a frame.
   -> REQ_READY[g]=0 for those cycles and beat_cnt holds at 3. The frame still completes with exactly 8 transfers and FRAME_DONE 3 cycles later than with no BP.
4. Owner stall: src0 drops valid for 5 cycles mid-frame while src1 is requesting.
   -> GRANT stays 01, OUT_VALID=0 and src1 REQ_READY=0. src1 is granted only after src0's eighth beat.
5. Reset mid-frame: RSTB pulsed low after beat 5.
   -> all outputs are 0 immediately. The next request from src1 alone gets GRANT=10 and a fresh 8-beat frame.
6. Fairness restart: src1 requests alone, completes a frame, then both sources request.
   -> src0 is granted next, because last_owner=1.
